neuron_mac_seq: RTL and testbench

- Sequential dot-product engine that reads one neuron's weights and the layer's input activations from two single-port inferred RAMs and produces one activated output per start.
- The RAMs have 1-cycle registered read latency; this block drives their addresses and consumes their q outputs.
- It accumulates signed fixed-point products, adds bias, applies ReLU with saturation, and hands the result downstream over a valid/ready handshake.
- A layer controller above it steps through neurons by issuing one start per neuron.

---
 rtl/nn_pkg.sv | 10 +
 rtl/fx_relu_sat.sv | 18 +
 rtl/neuron_mac_seq.sv | 90 +++++++++
 tb/tb_neuron_mac_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding, default widths and accumulator sizing helper
package nn_pkg;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FINISH, OUT} state_t;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int FRAC_BITS_DEF  = 8;
  function automatic int min_acc_width(input int data_width, input int n_inputs);
    return 2 * data_width + $clog2(n_inputs);
  endfunction
endpackage

// File: rtl/fx_relu_sat.sv
// fx_relu_sat: bias add, fixed-point rescale, ReLU and saturation to DATA_WIDTH
module fx_relu_sat
  import nn_pkg::*;
#(
  parameter int ACC_WIDTH  = 42,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic        [DATA_WIDTH-1:0] y
);
  localparam logic signed [ACC_WIDTH-1:0] MAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  logic signed [ACC_WIDTH-1:0] r;
  // bias is Q(FRAC_BITS) while acc is Q(2*FRAC_BITS); align before summing
  assign r = (acc + (ACC_WIDTH'(bias) <<< FRAC_BITS)) >>> FRAC_BITS;
  assign y = r < 0 ? '0 : r > MAX ? MAX[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential weight x activation dot product over two
// 1-cycle-latency RAMs, followed by bias, ReLU and saturation
module neuron_mac_seq
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int N_INPUTS   = 784,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int ACC_WIDTH  = 42
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic        [ADDR_WIDTH-1:0] w_base,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic        [ADDR_WIDTH-1:0] w_addr,
  output logic        [ADDR_WIDTH-1:0] x_addr,
  input  logic signed [DATA_WIDTH-1:0] w_q,
  input  logic signed [DATA_WIDTH-1:0] x_q,
  output logic                         busy,
  output logic        [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);
  state_t state, state_nx;
  logic        [ADDR_WIDTH-1:0]   cnt, base_q;
  logic signed [DATA_WIDTH-1:0]   bias_q;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic        [DATA_WIDTH-1:0]   res;
  logic                           pipe, last;
  assign prod = w_q * x_q;
  assign last = cnt == ADDR_WIDTH'(N_INPUTS - 1);
  assign busy = state != IDLE;
  fx_relu_sat #(.ACC_WIDTH(ACC_WIDTH), .DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_act (
    .acc(acc), .bias(bias_q), .y(res)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = last ? DRAIN : RUN;
      DRAIN:   state_nx = FINISH;
      FINISH:  state_nx = OUT;
      OUT:     state_nx = out_valid && out_ready ? IDLE : OUT;
      default: state_nx = IDLE;
    endcase
  end
  // pipe marks that RAM q carries a product issued one cycle earlier
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt       <= '0;
      base_q    <= '0;
      bias_q    <= '0;
      acc       <= '0;
      pipe      <= 1'b0;
      w_addr    <= '0;
      x_addr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (pipe) acc <= acc + ACC_WIDTH'(prod);
      case (state)
        IDLE: if (start) begin
          base_q <= w_base;
          bias_q <= bias;
          acc    <= '0;
          cnt    <= '0;
          w_addr <= w_base;
          x_addr <= '0;
        end
        RUN: begin
          pipe <= 1'b1;
          if (!last) begin
            cnt    <= cnt + 1'b1;
            w_addr <= base_q + cnt + 1'b1;
            x_addr <= cnt + 1'b1;
          end
        end
        DRAIN:  pipe <= 1'b0;
        FINISH: out_data <= res;
        OUT:    out_valid <= !out_valid || !out_ready;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: directed checks of addressing, latency, activation and handshake
module tb_neuron_mac_seq;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [9:0] w_base = '0, w_addr, x_addr;
  logic signed [15:0] bias = '0, w_q, x_q;
  logic [15:0] out_data;
  logic busy, out_valid;
  logic signed [15:0] wmem [1024];
  logic signed [15:0] xmem [1024];
  int n_chk = 0, n_fail = 0;

  neuron_mac_seq #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .N_INPUTS(4), .FRAC_BITS(8), .ACC_WIDTH(42)) dut (
    .clk(clk), .reset(reset), .start(start), .w_base(w_base), .bias(bias),
    .w_addr(w_addr), .x_addr(x_addr), .w_q(w_q), .x_q(x_q), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    w_q <= wmem[w_addr];
    x_q <= xmem[x_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_check(input string tag, input logic [9:0] b, input logic [15:0] bi,
                           input logic [15:0] exp, input bit poke);
    int n;
    start = 1'b1; w_base = b; bias = bi;
    step();
    start = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    for (int k = 0; k < 4; k++) begin
      check({tag, " w_addr"}, w_addr, 32'(10'(b + 10'(k))));
      check({tag, " x_addr"}, x_addr, k);
      if (k == 1 && poke) begin
        start = 1'b1; w_base = 10'h155; bias = 16'h1234;
      end
      if (k < 3) step();
      start = 1'b0;
    end
    n = 3;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, " valid edge"}, n, 7);
    check({tag, " out_data"}, out_data, exp);
    check({tag, " busy in OUT"}, busy, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " valid drop"}, out_valid, 0);
    check({tag, " idle after hs"}, busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = 16'sh0200;
      xmem[i] = 16'sh0100;
    end
    for (int i = 0; i < 4; i++) begin
      wmem[10'h200 + i] = 16'shFF00;
      wmem[10'h210 + i] = 16'sh0000;
      wmem[10'h300 + i] = 16'sh7FFF;
    end
    wmem[10'h210] = 16'shFFFF;
    repeat (2) step();
    check("reset busy", busy, 0);
    check("reset valid", out_valid, 0);
    check("reset data", out_data, 0);
    check("reset w_addr", w_addr, 0);
    reset = 1'b0;
    step();
    check("idle no start", busy, 0);
    run_check("basic", 10'h000, 16'h0080, 16'h0880, 1'b0);
    run_check("base100", 10'h100, 16'h0000, 16'h0800, 1'b1);
    run_check("wrap", 10'h3FE, 16'h0000, 16'h0800, 1'b0);
    run_check("relu", 10'h200, 16'h0100, 16'h0000, 1'b0);
    run_check("trunc neg", 10'h210, 16'h0000, 16'h0000, 1'b0);
    run_check("trunc bias", 10'h210, 16'h0002, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) xmem[i] = 16'sh7FFF;
    run_check("sat", 10'h300, 16'h7FFF, 16'h7FFF, 1'b0);
    for (int i = 0; i < 4; i++) xmem[i] = 16'sh0100;
    // backpressure with a stray start while the result waits
    start = 1'b1; w_base = '0; bias = 16'h0080;
    step();
    start = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) step();
    for (int i = 0; i < 5; i++) begin
      start = i == 2;
      step();
      check("bp valid", out_valid, 1);
      check("bp data", out_data, 16'h0880);
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (3) step();
    check("no extra job busy", busy, 0);
    check("no extra job valid", out_valid, 0);
    // asynchronous reset in the middle of RUN
    start = 1'b1; w_base = 10'h300; bias = 16'h7FFF;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("arst busy", busy, 0);
    check("arst w_addr", w_addr, 0);
    check("arst x_addr", x_addr, 0);
    check("arst data", out_data, 0);
    check("arst valid", out_valid, 0);
    step();
    reset = 1'b0;
    step();
    run_check("after reset", 10'h000, 16'h0080, 16'h0880, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
